// File: rtl/nor4_response_checker.sv
// Clocked response checker for a four-input NOR gate: compares the sampled gate
// output against ~(a|b|c|d), counts samples/errors, tracks vector coverage and grades the run.
module nor4_response_checker #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sample_en,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             d,
  input  logic             e,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [15:0]      cov_mask,
  output logic             first_err_valid,
  output logic [3:0]       first_err_vec
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic nor4_expected(input logic [3:0] vec);
    return ~(|vec);
  endfunction

  state_t           state_q;
  logic [CNT_W-1:0] err_cnt_q;
  logic [CNT_W-1:0] sample_cnt_q;
  logic [15:0]      cov_mask_q;
  logic             first_err_valid_q;
  logic [3:0]       first_err_vec_q;
  logic             pass_q;

  logic [3:0]       vec_s;
  logic             mismatch_s;
  logic [CNT_W-1:0] sample_cnt_d;
  logic [CNT_W-1:0] err_cnt_d;
  logic [15:0]      cov_mask_d;
  logic             finish_s;

  // Candidate statistics if the current cycle's sample is accepted in RUN.
  always_comb begin
    vec_s        = {a, b, c, d};
    mismatch_s   = (e != nor4_expected(vec_s));
    sample_cnt_d = sample_cnt_q;
    err_cnt_d    = err_cnt_q;
    if (sample_cnt_q != CNT_MAX) begin
      sample_cnt_d = sample_cnt_q + CNT_ONE;
    end else begin
      sample_cnt_d = sample_cnt_q;
    end
    if (mismatch_s && (err_cnt_q != CNT_MAX)) begin
      err_cnt_d = err_cnt_q + CNT_ONE;
    end else begin
      err_cnt_d = err_cnt_q;
    end
    cov_mask_d = cov_mask_q | (16'd1 << vec_s);
    finish_s   = (cov_mask_d == 16'hFFFF) || (sample_cnt_d == CNT_MAX);
  end

  // Control FSM and statistics registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= IDLE;
      err_cnt_q         <= '0;
      sample_cnt_q      <= '0;
      cov_mask_q        <= 16'h0000;
      first_err_valid_q <= 1'b0;
      first_err_vec_q   <= 4'h0;
      pass_q            <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          // start has priority over any sample presented on the same edge
          if (start) begin
            state_q           <= RUN;
            err_cnt_q         <= '0;
            sample_cnt_q      <= '0;
            cov_mask_q        <= 16'h0000;
            first_err_valid_q <= 1'b0;
            first_err_vec_q   <= 4'h0;
            pass_q            <= 1'b0;
          end
        end
        RUN: begin
          if (sample_en) begin
            sample_cnt_q <= sample_cnt_d;
            err_cnt_q    <= err_cnt_d;
            cov_mask_q   <= cov_mask_d;
            if (mismatch_s && !first_err_valid_q) begin
              first_err_valid_q <= 1'b1;
              first_err_vec_q   <= vec_s;
            end
            if (finish_s) begin
              state_q <= DONE;
              pass_q  <= (err_cnt_d == '0) && (cov_mask_d == 16'hFFFF);
            end
          end
        end
        default: begin
          state_q <= IDLE;
          pass_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy            = (state_q == RUN);
  assign done            = (state_q == DONE);
  assign pass            = pass_q;
  assign err_cnt         = err_cnt_q;
  assign sample_cnt      = sample_cnt_q;
  assign cov_mask        = cov_mask_q;
  assign first_err_valid = first_err_valid_q;
  assign first_err_vec   = first_err_vec_q;

endmodule

// File: tb/tb_nor4_response_checker.sv
// Directed self-checking bench for nor4_response_checker (CNT_W=8 and CNT_W=4 instances).
module tb_nor4_response_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic sample_en = 1'b0;
  logic a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0, e = 1'b0;

  logic        busy, done, pass, fev;
  logic [7:0]  err_cnt, sample_cnt;
  logic [15:0] cov_mask;
  logic [3:0]  fvec;

  logic        busy4, done4, pass4, fev4;
  logic [3:0]  err_cnt4, sample_cnt4;
  logic [15:0] cov_mask4;
  logic [3:0]  fvec4;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  nor4_response_checker #(.CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .start(start), .sample_en(sample_en),
    .a(a), .b(b), .c(c), .d(d), .e(e),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .sample_cnt(sample_cnt), .cov_mask(cov_mask),
    .first_err_valid(fev), .first_err_vec(fvec)
  );

  nor4_response_checker #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start), .sample_en(sample_en),
    .a(a), .b(b), .c(c), .d(d), .e(e),
    .busy(busy4), .done(done4), .pass(pass4), .err_cnt(err_cnt4),
    .sample_cnt(sample_cnt4), .cov_mask(cov_mask4),
    .first_err_valid(fev4), .first_err_vec(fvec4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic st, input logic se, input logic [3:0] v, input logic ev);
    @(negedge clk);
    start = st;
    sample_en = se;
    {a, b, c, d} = v;
    e = ev;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    start = 1'b0;
    sample_en = 1'b0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    // reset state
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_sample", sample_cnt, 0);
    chk("rst_cov", cov_mask, 0);
    do_reset();

    // sample_en ignored in IDLE
    tick(1'b0, 1'b1, 4'd3, 1'b0);
    chk("idle_ignore_sample", sample_cnt, 0);
    chk("idle_busy", busy, 0);

    // correct DUT, ordered sweep
    tick(1'b1, 1'b0, 4'd0, 1'b0);
    chk("start_busy", busy, 1);
    for (int v = 0; v < 16; v++) begin
      tick(1'b0, 1'b1, 4'(v), (v == 0) ? 1'b1 : 1'b0);
      if (v == 14) chk("sweep_not_done_15", {busy, done}, 2'b10);
    end
    chk("sweep_done", {busy, done}, 2'b01);
    chk("sweep_pass", pass, 1);
    chk("sweep_sample", sample_cnt, 16);
    chk("sweep_err", err_cnt, 0);
    chk("sweep_cov", cov_mask, 16'hFFFF);
    chk("sweep_fev", fev, 0);
    tick(1'b0, 1'b1, 4'd0, 1'b0);
    chk("done_frozen", sample_cnt, 16);

    // stuck-at-0 output
    do_reset();
    tick(1'b1, 1'b0, 4'd0, 1'b0);
    for (int v = 0; v < 16; v++) tick(1'b0, 1'b1, 4'(v), 1'b0);
    chk("sa0_done", done, 1);
    chk("sa0_err", err_cnt, 1);
    chk("sa0_fvec", fvec, 4'b0000);
    chk("sa0_fev", fev, 1);
    chk("sa0_pass", pass, 0);

    // inverted output, two sweeps
    do_reset();
    tick(1'b1, 1'b0, 4'd0, 1'b0);
    for (int v = 0; v < 16; v++) tick(1'b0, 1'b1, 4'(v), (v == 0) ? 1'b0 : 1'b1);
    chk("inv_done16", done, 1);
    for (int v = 0; v < 16; v++) tick(1'b0, 1'b1, 4'(v), (v == 0) ? 1'b0 : 1'b1);
    chk("inv_err", err_cnt, 16);
    chk("inv_sample", sample_cnt, 16);
    chk("inv_fvec", fvec, 4'd0);
    chk("inv_pass", pass, 0);

    // timeout with CNT_W=4, repeat 0101 (expected e=0)
    do_reset();
    tick(1'b1, 1'b0, 4'd0, 1'b0);
    for (int i = 0; i < 15; i++) begin
      tick(1'b0, 1'b1, 4'b0101, 1'b0);
      if (i == 13) chk("to_not_done_14", done4, 0);
    end
    chk("to_done", done4, 1);
    chk("to_sample", sample_cnt4, 15);
    chk("to_err", err_cnt4, 0);
    chk("to_cov", cov_mask4, 16'h0020);
    chk("to_pass", pass4, 0);

    // restart ignored mid-RUN, then start+sample in DONE
    do_reset();
    tick(1'b1, 1'b0, 4'd0, 1'b0);
    for (int v = 0; v < 5; v++) tick(1'b0, 1'b1, 4'(v), (v == 0) ? 1'b1 : 1'b0);
    tick(1'b1, 1'b0, 4'd0, 1'b0);
    chk("mid_start_busy", busy, 1);
    chk("mid_start_cnt", sample_cnt, 5);
    for (int v = 5; v < 16; v++) tick(1'b0, 1'b1, 4'(v), 1'b0);
    chk("mid_start_done", done, 1);
    chk("mid_start_total", sample_cnt, 16);
    tick(1'b1, 1'b1, 4'd0, 1'b0);
    chk("restart_busy", {busy, done}, 2'b10);
    chk("restart_sample", sample_cnt, 0);
    chk("restart_err", err_cnt, 0);
    chk("restart_cov", cov_mask, 0);
    chk("restart_fev", fev, 0);
    chk("restart_pass", pass, 0);

    // asynchronous reset between edges
    do_reset();
    tick(1'b1, 1'b0, 4'd0, 1'b0);
    for (int v = 0; v < 7; v++) tick(1'b0, 1'b1, 4'(v), (v == 0) ? 1'b1 : 1'b0);
    chk("pre_arst_cnt", sample_cnt, 7);
    @(negedge clk);
    sample_en = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_sample", sample_cnt, 0);
    chk("arst_cov", cov_mask, 0);
    chk("arst_done", done, 0);
    rst = 1'b0;
    tick(1'b0, 1'b1, 4'd0, 1'b1);
    chk("arst_idle", {busy, done, sample_cnt}, 10'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/nor4_response_checker.md
# nor4_response_checker

Clocked self-checking monitor for the four-input NOR gate. It samples the four gate inputs and the gate output on sampled cycles and compares the output against the expected NOR value. It accumulates error and sample counts, tracks coverage of all 16 input combinations, and reports pass/fail once coverage is complete. It sits beside the NOR gate under test and consumes the stimulus that the stimulus generator drives, so a bench or on-board harness needs only to read `done`/`pass`.

## Interface
- `CNT_W`, default 8: width of the sample and error counters; both saturate at 2^CNT_W-1.
- `clk` input 1: single clock, rising-edge active.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: begin or restart a check run; single-cycle pulse, level tolerated.
- `sample_en` input 1: sample `a..e` this cycle.
- `a`, `b`, `c`, `d` input 1 each: gate inputs, as driven to the DUT.
- `e` input 1: DUT output.
- `busy` output 1: state is RUN.
- `done` output 1: state is DONE.
- `pass` output 1: valid while `done`; high when `err_cnt`==0 and `cov_mask`==16'hFFFF.
- `err_cnt` output CNT_W: number of mismatching samples.
- `sample_cnt` output CNT_W: number of accepted samples.
- `cov_mask` output 16: bit i set once vector i has been seen; i = {a,b,c,d}, with a as MSB.
- `first_err_valid` output 1: at least one mismatch has been captured this run.
- `first_err_vec` output 4: {a,b,c,d} of the first mismatching sample.

## Operation
- **States:** IDLE, RUN, DONE; 2-bit encoded, registered.
- **Reset:** asynchronous; all outputs 0, state IDLE.
- **IDLE:**
  - `sample_en` is ignored.
  - `start` moves to RUN and clears `err_cnt`, `sample_cnt`, `cov_mask`, `first_err_valid` and `first_err_vec` on the same edge.
- **RUN, on each edge with `sample_en`=1:**
  - expected = ~(a|b|c|d); mismatch = (e != expected).
  - `sample_cnt` increments, saturating.
  - On mismatch, `err_cnt` increments, saturating.
  - On mismatch with `first_err_valid`=0, capture `first_err_vec`={a,b,c,d} and set `first_err_valid`. Later mismatches do not overwrite it.
  - Set `cov_mask`[{a,b,c,d}].
- **RUN to DONE:** occurs on the same edge as a sample when either:
  - the updated `cov_mask` equals 16'hFFFF, or
  - the updated `sample_cnt` equals 2^CNT_W-1 (timeout).
- **`start` during RUN:** ignored.
- **`start` during DONE:** moves to RUN with all statistics cleared, exactly as from IDLE.
- **DONE:**
  - `sample_en` is ignored and all statistics are frozen.
  - `pass` = (`err_cnt`==0) && (`cov_mask`==16'hFFFF).
  - A timeout with incomplete coverage gives `pass`=0 even when `err_cnt`==0.
- **Simultaneous `start` and `sample_en` in IDLE or DONE:** `start` wins, and that sample is not counted.
- **Outputs:** `pass` is 0 outside DONE.
- **Saturation:** neither counter wraps. `err_cnt` saturating does not block the transition to DONE.

## Timing
- All outputs are registered and change only on the rising edge of `clk` or on `rst`.
- Sample latency: statistics reflect a sample one edge after the edge that accepted it.
- `done` rises on the edge that accepts the completing sample. It is visible in the following cycle, with `busy` dropping at the same time.
- `start` to `busy`: one edge.
- `rst` asserted mid-RUN forces IDLE immediately and clears every output, without waiting for a clock edge.
- Inputs `a..e` must be stable around the rising edge while `sample_en`=1; the bench changes stimulus away from the active edge.

## Test plan
- **Correct DUT, ordered sweep:** reset, pulse `start`, then drive vectors 0..15 with `sample_en`=1 on 16 consecutive cycles.
  - Required: `done`=1, `pass`=1, `sample_cnt`=16, `err_cnt`=0, `cov_mask`=16'hFFFF, `first_err_valid`=0.
- **Stuck-at-0 DUT output:** hold `e`=0 and sweep 0..15.
  - Required: `err_cnt`=1, `first_err_vec`=4'b0000, `first_err_valid`=1, `pass`=0.
- **Inverted DUT output:** drive `e`=a|b|c|d and sweep 0..15 twice.
  - Required: `done` after 16 samples, `err_cnt`=16, `sample_cnt`=16, `first_err_vec`=0, and the second sweep is ignored.
- **Timeout with CNT_W=4:** repeat only vector 4'b0101 with a correct `e`.
  - Required: `done` after 15 samples, `sample_cnt`=15, `err_cnt`=0, `cov_mask`=16'h0020, `pass`=0.
- **Restart and priority:**
  - Pulse `start` mid-RUN after 5 samples: the run continues and `sample_cnt` keeps counting from 5.
  - In DONE, assert `start` together with `sample_en`: the state returns to RUN with all statistics 0 and that sample is not counted.
- **Asynchronous reset:** assert `rst` between clock edges in RUN after 7 samples.
  - Required: `busy`, `sample_cnt` and `cov_mask` go to 0 before the next edge, and the state is IDLE.
